// File: rtl/sram_bank_pkg.sv
// Shared constants for the phase-clocked register bank: geometry, default phase count
// and the phase indices at which the bank samples its inputs.
package sram_bank_pkg;

  localparam int AW            = 5;
  localparam int DW            = 16;
  localparam int WIDTH_DEFAULT = 10;

  localparam int PH_ADDR  = 2;
  localparam int PH_DATA  = 4;
  localparam int PH_SRCLK = 6;
  localparam int PH_READ  = 7;
  localparam int PH_WRITE = 9;

  typedef enum logic {
    GEN_IDLE = 1'b0,
    GEN_RUN  = 1'b1
  } gen_state_e;

endpackage

// File: rtl/bennett_phase_gen.sv
// Square Bennett clock generator: a step counter over 2*WIDTH clks that raises the
// phase clocks one by one, then drops them in reverse order.
module bennett_phase_gen
  import sram_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [WIDTH-1:0]            clkp,
  output logic                        mclk,
  output logic                        inst_flag,
  output logic [$clog2(2*WIDTH)-1:0]  next_step
);

  localparam int SW = $clog2(2*WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(2*WIDTH-1);

  gen_state_e       state_reg, state_next;
  logic [SW-1:0]    step_reg, step_next;
  logic [WIDTH-1:0] clkp_reg, clkp_next;
  logic             mclk_reg, inst_flag_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= GEN_IDLE;
      step_reg      <= '0;
      clkp_reg      <= '0;
      mclk_reg      <= 1'b0;
      inst_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      clkp_reg      <= clkp_next;
      mclk_reg      <= (step_next >= SW'(WIDTH));
      inst_flag_reg <= (step_next == '0);
    end
  end

  // Leaving idle enters step 0 without advancing, so the first cycle after reset is complete.
  always_comb begin
    state_next = GEN_RUN;
    step_next  = '0;
    clkp_next  = clkp_reg;
    if (state_reg == GEN_RUN)
      step_next = (step_reg == LAST_STEP) ? '0 : step_reg + 1'b1;
    if (step_next < SW'(WIDTH))
      clkp_next = clkp_reg | (WIDTH'(1) << step_next);
    else
      clkp_next = clkp_reg & ~(WIDTH'(1) << (LAST_STEP - step_next));
  end

  assign clkp      = clkp_reg;
  assign mclk      = mclk_reg;
  assign inst_flag = inst_flag_reg;
  assign next_step = step_next;

endmodule

// File: rtl/sram_2port_bank_sys.sv
// Phase-clocked 32x16 register bank: port A read/write, port B read-only, with the
// Bennett phase generator supplying the timing and the shift-register clock gating.
module sram_2port_bank_sys
  import sram_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    addr_a,
  input  logic [AW-1:0]    addr_b,
  input  logic [DW-1:0]    din,
  input  logic             read_en,
  input  logic             reg_wrt_bar,
  input  logic             write_en,
  output logic [WIDTH-1:0] clkp,
  output logic             mclk,
  output logic             inst_flag,
  output logic             srclk_neg,
  output logic             srclk_pos,
  output logic [DW-1:0]    out_a,
  output logic [DW-1:0]    out_b
);

  localparam int SW    = $clog2(2*WIDTH);
  localparam int DEPTH = 2**AW;

  logic [SW-1:0] next_step;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] out_a_reg, out_b_reg;
  logic          read_edge, uncompute_edge, write_hit;

  bennett_phase_gen #(.WIDTH(WIDTH)) u_phase_gen (
    .clk       (clk),
    .reset     (reset),
    .clkp      (clkp),
    .mclk      (mclk),
    .inst_flag (inst_flag),
    .next_step (next_step)
  );

  assign read_edge      = (next_step == SW'(PH_READ));
  assign uncompute_edge = (next_step == SW'(2*WIDTH-1-PH_READ));
  assign write_hit      = (next_step == SW'(PH_WRITE)) && write_en && reg_wrt_bar;

  // Read data lives only while clkp[PH_READ] is high, then returns to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_a_reg <= '0;
      out_b_reg <= '0;
    end else if (read_edge) begin
      out_b_reg <= read_en ? mem[addr_b] : '0;
      out_a_reg <= (read_en && !reg_wrt_bar) ? mem[addr_a] : '0;
    end else if (uncompute_edge) begin
      out_a_reg <= '0;
      out_b_reg <= '0;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (reset)
          mem[gi] <= '0;
        else if (write_hit && (addr_a == AW'(gi)))
          mem[gi] <= din;
      end
    end
  endgenerate

  assign srclk_neg = ~mclk & clkp[PH_SRCLK];
  assign srclk_pos = ~srclk_neg;
  assign out_a     = out_a_reg;
  assign out_b     = out_b_reg;

endmodule

// File: tb/tb_sram_2port_bank_sys.sv
// Directed bench for the phase-clocked register bank: a step/memory model checked every
// clk, plus literal expectations at the key points of each transaction.
module tb_sram_2port_bank_sys;
  localparam int W  = 10;
  localparam int P  = 2*W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  addr_a = '0, addr_b = '0;
  logic [15:0] din = '0;
  logic        read_en = 1'b0, reg_wrt_bar = 1'b0, write_en = 1'b0;
  logic [W-1:0] clkp;
  logic        mclk, inst_flag, srclk_neg, srclk_pos;
  logic [15:0] out_a, out_b;

  int vectors = 0;
  int miscompares = 0;

  // model state
  bit          m_seen_reset = 0;
  bit          m_run = 0;
  int          m_s = 0;
  logic [15:0] m_mem [32];
  logic [15:0] m_out_a = '0, m_out_b = '0;

  sram_2port_bank_sys #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b), .din(din),
    .read_en(read_en), .reg_wrt_bar(reg_wrt_bar), .write_en(write_en),
    .clkp(clkp), .mclk(mclk), .inst_flag(inst_flag), .srclk_neg(srclk_neg),
    .srclk_pos(srclk_pos), .out_a(out_a), .out_b(out_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_clkp(input int s);
    int n;
    n = (s < W) ? s + 1 : P - 1 - s;   // number of phases high in step s
    return W'((32'd1 << n) - 1);
  endfunction

  // Model update at each edge, then compare shortly after it.
  always @(posedge clk) begin
    if (reset) begin
      m_seen_reset = 1;
      m_run = 0;
      m_s = 0;
      m_out_a = '0;
      m_out_b = '0;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
    end else if (m_seen_reset) begin
      if (!m_run) begin
        m_run = 1;
        m_s = 0;
      end else begin
        m_s = (m_s + 1) % P;
      end
      if (m_s == 7) begin
        m_out_b = read_en ? m_mem[addr_b] : 16'h0;
        m_out_a = (read_en && !reg_wrt_bar) ? m_mem[addr_a] : 16'h0;
      end
      if (m_s == P - 1 - 7) begin
        m_out_a = '0;
        m_out_b = '0;
      end
      if (m_s == 9 && write_en && reg_wrt_bar) m_mem[addr_a] = din;
    end
    #1;
    if (m_seen_reset) begin
      check("clkp",      clkp,      m_run ? exp_clkp(m_s) : '0);
      check("mclk",      mclk,      m_run && m_s >= W);
      check("inst_flag", inst_flag, m_run && m_s == 0);
      check("srclk_neg", srclk_neg, m_run && m_s >= 6 && m_s <= 9);
      check("srclk_pos", srclk_pos, !(m_run && m_s >= 6 && m_s <= 9));
      check("out_a",     out_a,     m_out_a);
      check("out_b",     out_b,     m_out_b);
    end
  end

  task automatic wait_step(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_run && m_s == k) && n < 100);
    if (!(m_run && m_s == k)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_step: step %0d not reached, at %0d", k, m_s);
    end
  endtask

  task automatic run_cycle(input logic [4:0] a, input logic [4:0] b, input logic [15:0] d,
                           input logic rd, input logic rwb, input logic we,
                           input bit chk, input logic [15:0] ea, input logic [15:0] eb);
    wait_step(1);  addr_a = a; addr_b = b;
    wait_step(3);  din = d;
    wait_step(5);  reg_wrt_bar = rwb;
    wait_step(6);  read_en = rd;
    wait_step(7);  read_en = 1'b0;
    if (chk) begin
      check("lit_out_a_read", out_a, ea);
      check("lit_out_b_read", out_b, eb);
    end
    wait_step(8);  write_en = we;
    wait_step(9);  write_en = 1'b0;
    wait_step(12);
    if (chk) begin
      check("lit_out_a_uncompute", out_a, 16'h0);
      check("lit_out_b_uncompute", out_b, 16'h0);
    end
    wait_step(18); reg_wrt_bar = 1'b0;
    $display("cycle a=%0d b=%0d din=%h rd=%0b rwb=%0b we=%0b out_a=%h out_b=%h",
             a, b, d, rd, rwb, we, ea, eb);
  endtask

  initial begin
    int pulses;
    @(negedge clk);
    @(negedge clk);
    check("lit_reset_clkp", clkp, '0);
    check("lit_reset_inst_flag", inst_flag, 1'b0);
    check("lit_reset_srclk_pos", srclk_pos, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("lit_first_clkp", clkp, 10'h001);
    check("lit_first_inst_flag", inst_flag, 1'b1);
    wait_step(9);
    check("lit_step9_clkp", clkp, 10'h3FF);
    wait_step(19);
    check("lit_step19_clkp", clkp, 10'h000);
    check("lit_step19_mclk", mclk, 1'b1);
    pulses = 0;
    for (int i = 0; i < 2*P; i++) begin
      @(negedge clk);
      if (inst_flag) pulses++;
    end
    check("lit_inst_pulses_2periods", pulses, 2);
    $display("reset/phase sequence done");

    run_cycle(5'd31, 5'd0,  16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);  // write 31
    run_cycle(5'd0,  5'd31, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'hAAAA);
    run_cycle(5'd5,  5'd0,  16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);  // write 5
    run_cycle(5'd5,  5'd0,  16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);  // blocked write
    run_cycle(5'd5,  5'd5,  16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234);
    run_cycle(5'd5,  5'd5,  16'h0100, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 16'h1234);  // same-cycle rd/wr
    run_cycle(5'd31, 5'd5,  16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h0100);
    run_cycle(5'd31, 5'd5,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);  // no read_en

    // Reset in the middle of a write cycle: pending write dropped, bank cleared.
    wait_step(1); addr_a = 5'd7; din = 16'hBEEF; reg_wrt_bar = 1'b1;
    wait_step(8); write_en = 1'b1; reset = 1'b1;
    @(negedge clk);
    write_en = 1'b0; reg_wrt_bar = 1'b0; reset = 1'b0;
    check("lit_midreset_clkp", clkp, '0);
    @(negedge clk);
    check("lit_midreset_restart", clkp, 10'h001);
    $display("mid-cycle reset applied");
    run_cycle(5'd7,  5'd31, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
